// File: rtl/alu_operand_stage_if.sv
// alu_operand_stage_if
//   Bundles the ID/EX operand stage bus: pipeline control (stall/flush),
//   decoded instruction fields, register-file read data, the EX/MEM and
//   MEM/WB write-back taps used for forwarding, and the registered ALU-side
//   outputs.
//   master : upstream decode / hazard logic (drives in_*, mem_*, wb_*, stall,
//            flush; observes the registered outputs)
//   slave  : alu_operand_stage itself
//   Parameters: WIDTH (datapath width), AW (register address width).
interface alu_operand_stage_if #(
  parameter int WIDTH = 32,
  parameter int AW    = 5
);
  logic             stall;
  logic             flush;
  logic             in_valid;
  logic [AW-1:0]    in_rs_addr;
  logic [AW-1:0]    in_rt_addr;
  logic [WIDTH-1:0] in_rs_data;
  logic [WIDTH-1:0] in_rt_data;
  logic [15:0]      in_imm16;
  logic [4:0]       in_shamt;
  logic             in_alusrc_a;
  logic             in_alusrc_b;
  logic             in_ext_op;
  logic             in_lui;
  logic [5:0]       in_alufun;
  logic             in_sign;
  logic             in_wr_en;
  logic [AW-1:0]    in_wr_addr;
  logic             mem_wr_en;
  logic [AW-1:0]    mem_wr_addr;
  logic [WIDTH-1:0] mem_wr_data;
  logic             wb_wr_en;
  logic [AW-1:0]    wb_wr_addr;
  logic [WIDTH-1:0] wb_wr_data;
  logic             out_valid;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [5:0]       ALUFun;
  logic             Sign;
  logic             out_wr_en;
  logic [AW-1:0]    out_wr_addr;

  modport master (
    output stall, flush, in_valid, in_rs_addr, in_rt_addr, in_rs_data,
           in_rt_data, in_imm16, in_shamt, in_alusrc_a, in_alusrc_b,
           in_ext_op, in_lui, in_alufun, in_sign, in_wr_en, in_wr_addr,
           mem_wr_en, mem_wr_addr, mem_wr_data, wb_wr_en, wb_wr_addr,
           wb_wr_data,
    input  out_valid, A, B, ALUFun, Sign, out_wr_en, out_wr_addr
  );

  modport slave (
    input  stall, flush, in_valid, in_rs_addr, in_rt_addr, in_rs_data,
           in_rt_data, in_imm16, in_shamt, in_alusrc_a, in_alusrc_b,
           in_ext_op, in_lui, in_alufun, in_sign, in_wr_en, in_wr_addr,
           mem_wr_en, mem_wr_addr, mem_wr_data, wb_wr_en, wb_wr_addr,
           wb_wr_data,
    output out_valid, A, B, ALUFun, Sign, out_wr_en, out_wr_addr
  );
endinterface

// File: rtl/alu_operand_stage.sv
// alu_operand_stage
//   ID/EX register stage in front of the ALU. Selects operand A (rs or
//   zero-extended shamt) and operand B (rt, zero/sign-extended imm16, or
//   LUI-shifted imm16), optionally forwards rs/rt from EX/MEM and MEM/WB,
//   and registers A, B, ALUFun, Sign plus the write-back tag.
//   Edge priority: reset > flush > stall > capture. in_valid=0 captures a
//   bubble identical to a flush.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-high reset
//   bus   : alu_operand_stage_if.slave (control, decode fields, forwarding
//           taps, registered outputs)
// Build option:
//   ALU_OPERAND_FWD_EN - when defined, rs/rt operands are forwarded from the
//   EX/MEM (higher priority) and MEM/WB write ports; register 0 is never
//   forwarded. When undefined, the mem_*/wb_* inputs are ignored.
module alu_operand_stage #(
  parameter int WIDTH = 32,
  parameter int AW    = 5
) (
  input logic            clk,
  input logic            reset,
  alu_operand_stage_if.slave bus
);

  logic             valid_q,   valid_d;
  logic [WIDTH-1:0] a_q,       a_d;
  logic [WIDTH-1:0] b_q,       b_d;
  logic [5:0]       alufun_q,  alufun_d;
  logic             sign_q,    sign_d;
  logic             wr_en_q,   wr_en_d;
  logic [AW-1:0]    wr_addr_q, wr_addr_d;

  logic [WIDTH-1:0] rs_val;
  logic [WIDTH-1:0] rt_val;
  logic [WIDTH-1:0] imm_ext;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;

`ifdef ALU_OPERAND_FWD_EN
  // EX/MEM holds the younger result, so it is checked before MEM/WB.
  always_comb begin
    rs_val = bus.in_rs_data;
    if (bus.in_rs_addr != '0) begin
      if (bus.mem_wr_en && (bus.mem_wr_addr == bus.in_rs_addr))
        rs_val = bus.mem_wr_data;
      else if (bus.wb_wr_en && (bus.wb_wr_addr == bus.in_rs_addr))
        rs_val = bus.wb_wr_data;
    end
  end

  always_comb begin
    rt_val = bus.in_rt_data;
    if (bus.in_rt_addr != '0) begin
      if (bus.mem_wr_en && (bus.mem_wr_addr == bus.in_rt_addr))
        rt_val = bus.mem_wr_data;
      else if (bus.wb_wr_en && (bus.wb_wr_addr == bus.in_rt_addr))
        rt_val = bus.wb_wr_data;
    end
  end
`else
  assign rs_val = bus.in_rs_data;
  assign rt_val = bus.in_rt_data;

  // Forwarding taps and register numbers are unused in this build.
  logic unused_fwd;
  assign unused_fwd = ^{bus.in_rs_addr, bus.in_rt_addr,
                        bus.mem_wr_en, bus.mem_wr_addr, bus.mem_wr_data,
                        bus.wb_wr_en, bus.wb_wr_addr, bus.wb_wr_data};
`endif

  // LUI takes precedence over the extension select.
  always_comb begin
    if (bus.in_lui)
      imm_ext = {bus.in_imm16, {(WIDTH-16){1'b0}}};
    else if (bus.in_ext_op)
      imm_ext = {{(WIDTH-16){bus.in_imm16[15]}}, bus.in_imm16};
    else
      imm_ext = {{(WIDTH-16){1'b0}}, bus.in_imm16};
  end

  assign op_a = bus.in_alusrc_a ? {{(WIDTH-5){1'b0}}, bus.in_shamt} : rs_val;
  assign op_b = bus.in_alusrc_b ? imm_ext : rt_val;

  always_comb begin
    valid_d   = valid_q;
    a_d       = a_q;
    b_d       = b_q;
    alufun_d  = alufun_q;
    sign_d    = sign_q;
    wr_en_d   = wr_en_q;
    wr_addr_d = wr_addr_q;
    if (bus.flush || (!bus.stall && !bus.in_valid)) begin
      // Bubble: ALUFun 000000 is ADD of zeros, harmless downstream.
      valid_d   = 1'b0;
      a_d       = '0;
      b_d       = '0;
      alufun_d  = '0;
      sign_d    = 1'b0;
      wr_en_d   = 1'b0;
      wr_addr_d = '0;
    end else if (!bus.stall) begin
      valid_d   = 1'b1;
      a_d       = op_a;
      b_d       = op_b;
      alufun_d  = bus.in_alufun;
      sign_d    = bus.in_sign;
      wr_en_d   = bus.in_wr_en;
      wr_addr_d = bus.in_wr_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q   <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      alufun_q  <= '0;
      sign_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
    end else begin
      valid_q   <= valid_d;
      a_q       <= a_d;
      b_q       <= b_d;
      alufun_q  <= alufun_d;
      sign_q    <= sign_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
    end
  end

  assign bus.out_valid   = valid_q;
  assign bus.A           = a_q;
  assign bus.B           = b_q;
  assign bus.ALUFun      = alufun_q;
  assign bus.Sign        = sign_q;
  assign bus.out_wr_en   = wr_en_q;
  assign bus.out_wr_addr = wr_addr_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
// tb_alu_operand_stage
//   Directed bench for alu_operand_stage: reset, capture, immediate
//   extension, shift operand, forwarding (or its absence when
//   ALU_OPERAND_FWD_EN is undefined), stall hold, flush-over-stall, bubble
//   capture and reset-over-stall.
module tb_alu_operand_stage;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  alu_operand_stage_if #(.WIDTH(32), .AW(5)) bus ();

  alu_operand_stage #(.WIDTH(32), .AW(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic v, input logic [31:0] a,
                         input logic [31:0] b, input logic [5:0] fun,
                         input logic s, input logic we);
    chk({tag, ".valid"},  {31'b0, bus.out_valid}, {31'b0, v});
    chk({tag, ".A"},      bus.A, a);
    chk({tag, ".B"},      bus.B, b);
    chk({tag, ".ALUFun"}, {26'b0, bus.ALUFun}, {26'b0, fun});
    chk({tag, ".Sign"},   {31'b0, bus.Sign}, {31'b0, s});
    chk({tag, ".wr_en"},  {31'b0, bus.out_wr_en}, {31'b0, we});
  endtask

  initial begin
    reset           = 1'b1;
    bus.stall       = 1'b0;
    bus.flush       = 1'b0;
    bus.in_valid    = 1'b1;
    bus.in_rs_addr  = 5'd1;
    bus.in_rt_addr  = 5'd2;
    bus.in_rs_data  = 32'd5;
    bus.in_rt_data  = 32'd7;
    bus.in_imm16    = 16'h0000;
    bus.in_shamt    = 5'd0;
    bus.in_alusrc_a = 1'b0;
    bus.in_alusrc_b = 1'b0;
    bus.in_ext_op   = 1'b0;
    bus.in_lui      = 1'b0;
    bus.in_alufun   = 6'b000000;
    bus.in_sign     = 1'b0;
    bus.in_wr_en    = 1'b1;
    bus.in_wr_addr  = 5'd9;
    bus.mem_wr_en   = 1'b0;
    bus.mem_wr_addr = 5'd0;
    bus.mem_wr_data = 32'h0;
    bus.wb_wr_en    = 1'b0;
    bus.wb_wr_addr  = 5'd0;
    bus.wb_wr_data  = 32'h0;

    // Reset for two cycles with a valid instruction present.
    tick();
    tick();
    chk_all("reset", 1'b0, 32'h0, 32'h0, 6'h00, 1'b0, 1'b0);
    chk("reset.wr_addr", {27'b0, bus.out_wr_addr}, 32'd0);

    // First capture after release.
    reset = 1'b0;
    tick();
    chk_all("cap", 1'b1, 32'd5, 32'd7, 6'h00, 1'b0, 1'b1);
    chk("cap.wr_addr", {27'b0, bus.out_wr_addr}, 32'd9);

    // Immediate extension variants.
    bus.in_alusrc_b = 1'b1;
    bus.in_imm16    = 16'hFFFE;
    bus.in_ext_op   = 1'b1;
    tick();
    chk("imm_sext.B", bus.B, 32'hFFFF_FFFE);
    bus.in_ext_op = 1'b0;
    tick();
    chk("imm_zext.B", bus.B, 32'h0000_FFFE);
    bus.in_ext_op = 1'b1;
    bus.in_lui    = 1'b1;
    tick();
    chk("imm_lui.B", bus.B, 32'hFFFE_0000);

    // Shift: A from shamt, B from rt.
    bus.in_alusrc_a = 1'b1;
    bus.in_alusrc_b = 1'b0;
    bus.in_lui      = 1'b0;
    bus.in_shamt    = 5'd4;
    bus.in_rt_data  = 32'h0000_000F;
    bus.in_alufun   = 6'b100000;
    bus.in_sign     = 1'b1;
    bus.in_wr_en    = 1'b0;
    tick();
    chk_all("shift", 1'b1, 32'h4, 32'hF, 6'b100000, 1'b1, 1'b0);

    // Forwarding.
    bus.in_alusrc_a = 1'b0;
    bus.in_alufun   = 6'b000000;
    bus.in_sign     = 1'b0;
    bus.in_rs_addr  = 5'd3;
    bus.in_rs_data  = 32'd1;
    bus.in_rt_addr  = 5'd3;
    bus.in_rt_data  = 32'd2;
    bus.mem_wr_en   = 1'b1;
    bus.mem_wr_addr = 5'd3;
    bus.mem_wr_data = 32'hAA;
    bus.wb_wr_en    = 1'b1;
    bus.wb_wr_addr  = 5'd3;
    bus.wb_wr_data  = 32'hBB;
    tick();
`ifdef ALU_OPERAND_FWD_EN
    chk("fwd_mem.A", bus.A, 32'hAA);
    chk("fwd_mem.B", bus.B, 32'hAA);
`else
    chk("nofwd_mem.A", bus.A, 32'd1);
    chk("nofwd_mem.B", bus.B, 32'd2);
`endif
    bus.mem_wr_en = 1'b0;
    tick();
`ifdef ALU_OPERAND_FWD_EN
    chk("fwd_wb.A", bus.A, 32'hBB);
    chk("fwd_wb.B", bus.B, 32'hBB);
`else
    chk("nofwd_wb.A", bus.A, 32'd1);
    chk("nofwd_wb.B", bus.B, 32'd2);
`endif
    bus.mem_wr_en   = 1'b1;
    bus.mem_wr_addr = 5'd0;
    bus.wb_wr_addr  = 5'd0;
    bus.in_rs_addr  = 5'd0;
    bus.in_rt_addr  = 5'd0;
    tick();
    chk("fwd_r0.A", bus.A, 32'd1);
    chk("fwd_r0.B", bus.B, 32'd2);

    // Stall: known state, then freeze while inputs change.
    bus.mem_wr_en  = 1'b0;
    bus.wb_wr_en   = 1'b0;
    bus.in_rs_addr = 5'd1;
    bus.in_rt_addr = 5'd2;
    bus.in_rs_data = 32'h11;
    bus.in_rt_data = 32'h22;
    bus.in_alufun  = 6'h05;
    bus.in_sign    = 1'b0;
    bus.in_wr_en   = 1'b1;
    bus.in_wr_addr = 5'd4;
    tick();
    chk_all("pre_stall", 1'b1, 32'h11, 32'h22, 6'h05, 1'b0, 1'b1);

    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.in_rs_data = 32'h33 + i;
      bus.in_rt_data = 32'h44 + i;
      bus.in_alufun  = 6'h07;
      bus.in_sign    = 1'b1;
      bus.in_wr_en   = 1'b0;
      bus.in_wr_addr = 5'd6;
      tick();
      chk_all("stall", 1'b1, 32'h11, 32'h22, 6'h05, 1'b0, 1'b1);
      chk("stall.wr_addr", {27'b0, bus.out_wr_addr}, 32'd4);
    end

    bus.stall = 1'b0;
    tick();
    chk_all("release", 1'b1, 32'h35, 32'h46, 6'h07, 1'b1, 1'b0);
    chk("release.wr_addr", {27'b0, bus.out_wr_addr}, 32'd6);

    // Flush wins over stall.
    bus.in_wr_en = 1'b1;
    bus.flush    = 1'b1;
    bus.stall    = 1'b1;
    tick();
    chk_all("flush_stall", 1'b0, 32'h0, 32'h0, 6'h00, 1'b0, 1'b0);

    // Reload, then capture a bubble via in_valid=0.
    bus.flush = 1'b0;
    bus.stall = 1'b0;
    tick();
    chk_all("reload", 1'b1, 32'h35, 32'h46, 6'h07, 1'b1, 1'b1);
    bus.in_valid = 1'b0;
    tick();
    chk_all("bubble", 1'b0, 32'h0, 32'h0, 6'h00, 1'b0, 1'b0);

    // Reset wins over stall.
    bus.in_valid = 1'b1;
    tick();
    bus.stall = 1'b1;
    reset     = 1'b1;
    tick();
    chk_all("reset_stall", 1'b0, 32'h0, 32'h0, 6'h00, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
